// File: rtl/cpu_step_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_step_controller: sole source of the CPU Go strobe (run/halt/step/bp)  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_step_controller #(
  parameter int CNT_MAX    = 12500000,
  parameter int DEB_CYCLES = 250000,
  parameter bit START_RUN  = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  Btns,
  input  logic        Turbo,
  input  logic [7:0]  IP,
  input  logic [7:0]  Bp_addr,
  input  logic        Bp_en,
  output logic        Go,
  output logic        Running,
  output logic        At_break,
  output logic [15:0] Go_count
);

  localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [27:0]      CNT_LAST = 28'(CNT_MAX);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  logic [2:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic       turbo_s1_q, turbo_s1_d, turbo_s2_q, turbo_s2_d;
  logic [1:0] sync_ok_q, sync_ok_d;
  logic [2:0] press;

  always_comb begin
    btn_s1_d   = Btns;
    btn_s2_d   = btn_s1_q;
    turbo_s1_d = Turbo;
    turbo_s2_d = turbo_s1_q;
    sync_ok_d  = {sync_ok_q[0], 1'b1};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      turbo_s1_q <= 1'b0;
      turbo_s2_q <= 1'b0;
      sync_ok_q  <= '0;
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      turbo_s1_q <= turbo_s1_d;
      turbo_s2_q <= turbo_s2_d;
      sync_ok_q  <= sync_ok_d;
    end
  end

  // A button only arms once it has been seen released after reset, so a
  // button held through reset cannot produce a press.
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      armed_d = armed_q | (sync_ok_q[1] & ~btn_s2_q[i]);
      if (btn_s2_q[i] != level_q) begin
        if (cnt_q == DEB_LAST) begin
          level_d = btn_s2_q[i];
          press_d = btn_s2_q[i] & armed_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        armed_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        armed_q <= armed_d;
        press_q <= press_d;
      end
    end

    assign press[i] = press_q;
  end

  state_t      state_q, state_d;
  logic [27:0] cnt_q, cnt_d;
  logic        go_q, go_d;
  logic        bp_skip_q, bp_skip_d;
  logic [15:0] go_count_q, go_count_d;
  logic        go_due, bp_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    go_d       = 1'b0;
    bp_skip_d  = bp_skip_q;
    go_count_d = go_count_q + 16'(go_q);
    go_due     = (cnt_q == CNT_LAST) | turbo_s2_q;
    bp_hit     = Bp_en & (IP == Bp_addr) & ~bp_skip_q;

    case (state_q)
      S_HALT: begin
        if (press[0])      state_d = S_RUN;
        else if (press[1]) state_d = S_STEP;
      end
      S_RUN: begin
        if (press[0]) begin
          state_d = S_HALT;
        end else begin
          cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 28'd1;
          if (go_due) begin
            if (bp_hit) state_d = S_BREAK;
            else        go_d    = 1'b1;
          end
        end
      end
      S_STEP: begin
        go_d    = 1'b1;
        state_d = S_HALT;
      end
      S_BREAK: begin
        if (press[0] | press[2]) state_d = S_RUN;
        else if (press[1])       state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase

    // Prescaler only runs while staying in RUN; any entry starts from zero.
    if (state_d != S_RUN || state_q != S_RUN) cnt_d = '0;

    if ((state_q == S_HALT || state_q == S_BREAK) && state_d != state_q)
      bp_skip_d = 1'b1;
    else if (go_d)
      bp_skip_d = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= START_RUN ? S_RUN : S_HALT;
      cnt_q      <= '0;
      go_q       <= 1'b0;
      bp_skip_q  <= 1'b1;
      go_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      go_q       <= go_d;
      bp_skip_q  <= bp_skip_d;
      go_count_q <= go_count_d;
    end
  end

  assign Go       = go_q;
  assign Running  = (state_q == S_RUN);
  assign At_break = (state_q == S_BREAK);
  assign Go_count = go_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_step_controller: self-checking bench for cpu_step_controller      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpu_step_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  Btns = '0;
  logic        Turbo = 1'b0;
  logic [7:0]  ip;
  logic [7:0]  Bp_addr = 8'h00;
  logic        Bp_en = 1'b0;
  logic        Go;
  logic        Running;
  logic        At_break;
  logic [15:0] Go_count;

  cpu_step_controller #(
    .CNT_MAX   (3),
    .DEB_CYCLES(4),
    .START_RUN (1'b1)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Btns    (Btns),
    .Turbo   (Turbo),
    .IP      (ip),
    .Bp_addr (Bp_addr),
    .Bp_en   (Bp_en),
    .Go      (Go),
    .Running (Running),
    .At_break(At_break),
    .Go_count(Go_count)
  );

  always #5 Clock = ~Clock;

  // Minimal CPU: IP advances on every Go.
  always @(posedge Clock) begin
    if (Reset)   ip <= 8'd0;
    else if (Go) ip <= ip + 8'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int go_seen  = 0;
  int g0       = 0;
  bit sb_on    = 1'b0;
  bit have_last = 1'b0;
  int exp_gap_q[$];

  typedef struct {
    logic turbo;
    int   gap;
    int   pulses;
  } vec_t;
  vec_t vecs[4];

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard: each Go pulse after the first pops one expected gap.
  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (Reset) begin
      go_seen = 0;
    end else if (Go) begin
      go_seen = go_seen + 1;
      if (sb_on) begin
        if (have_last && exp_gap_q.size() > 0)
          check("go_gap", cyc - last_cyc, exp_gap_q.pop_front());
        have_last = 1'b1;
        last_cyc  = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic sample();
    @(negedge Clock);
    #1;
  endtask

  task automatic arm_gaps(input int gap, input int n);
    have_last = 1'b0;
    for (int i = 0; i < n; i++) exp_gap_q.push_back(gap);
    sb_on = 1'b1;
  endtask

  task automatic wait_sb(input int bound);
    int k = 0;
    while (exp_gap_q.size() != 0 && k < bound) begin
      @(negedge Clock);
      k++;
    end
    #1;
    check("sb_drain", exp_gap_q.size(), 0);
    exp_gap_q.delete();
    sb_on = 1'b0;
  endtask

  task automatic wait_break(input int bound);
    int k = 0;
    while (At_break !== 1'b1 && k < bound) begin
      @(negedge Clock);
      k++;
    end
    #1;
    check("wait_break", int'(At_break), 1);
  endtask

  task automatic press_btn(input int b);
    Btns[b] = 1'b1;
    tick(10);
    Btns[b] = 1'b0;
    tick(10);
  endtask

  initial begin
    vecs[0] = '{turbo: 1'b1, gap: 1, pulses: 8};
    vecs[1] = '{turbo: 1'b0, gap: 4, pulses: 4};
    vecs[2] = '{turbo: 1'b1, gap: 1, pulses: 5};
    vecs[3] = '{turbo: 1'b0, gap: 4, pulses: 3};

    // Reset state and free-running RUN cadence
    tick(3);
    sample();
    check("rst_go", int'(Go), 0);
    check("rst_go_count", int'(Go_count), 0);
    check("rst_running", int'(Running), 1);
    tick(0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    arm_gaps(4, 4);
    wait_sb(100);
    @(posedge Clock);
    sample();
    check("go_count_5", int'(Go_count), 5);
    check("running_run", int'(Running), 1);

    // Turbo latency: Go every cycle from the 3rd edge after Turbo rises
    tick(0);
    Turbo = 1'b1;
    repeat (3) @(posedge Clock);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("turbo_go", int'(Go), 1);
    end

    for (int v = 0; v < 4; v++) begin
      tick(0);
      Turbo = vecs[v].turbo;
      tick(8);
      arm_gaps(vecs[v].gap, vecs[v].pulses);
      wait_sb(200);
    end

    // HALT, then a bouncy single-step
    Turbo = 1'b0;
    tick(2);
    press_btn(0);
    sample();
    check("halt_running", int'(Running), 0);
    g0 = go_seen;
    tick(20);
    sample();
    check("halt_no_go", go_seen - g0, 0);
    tick(0);
    Btns[1] = 1'b1; tick(1);
    Btns[1] = 1'b0; tick(1);
    Btns[1] = 1'b1; tick(10);
    Btns[1] = 1'b0; tick(10);
    sample();
    check("step_one_go", go_seen - g0, 1);
    check("step_back_halt", int'(Running), 0);
    check("step_not_break", int'(At_break), 0);
    check("step_go_count", int'(Go_count), go_seen);

    // Breakpoint at 0x05 from a fresh reset
    tick(0);
    Bp_en = 1'b1;
    Bp_addr = 8'h05;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    wait_break(200);
    check("bp_ip", int'(ip), 5);
    check("bp_go_count", int'(Go_count), 5);
    g0 = go_seen;
    tick(100);
    sample();
    check("bp_no_go", go_seen - g0, 0);
    check("bp_held", int'(At_break), 1);
    check("bp_go_low", int'(Go), 0);

    // Resume executes 0x05, runs round the 8-bit IP space and breaks again
    tick(0);
    press_btn(2);
    sample();
    check("resume_running", int'(Running), 1);
    check("resume_left_break", int'(At_break), 0);
    wait_break(2000);
    check("rebreak_ip", int'(ip), 5);
    check("rebreak_go_count", int'(Go_count), 261);

    // Button held through reset must not toggle the run state
    tick(0);
    Bp_en = 1'b0;
    Btns = 3'b001;
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(20);
    sample();
    check("held_rst_running", int'(Running), 1);
    tick(0);
    Btns = 3'b000;
    tick(10);
    press_btn(0);
    sample();
    check("after_release_halt", int'(Running), 0);

    // Simultaneous run/stop and step in HALT: run/stop wins
    tick(0);
    Btns = 3'b011;
    tick(10);
    Btns = 3'b000;
    tick(10);
    sample();
    check("prio_running", int'(Running), 1);

    // Reset in the middle of turbo RUN
    tick(0);
    Turbo = 1'b1;
    tick(6);
    sample();
    check("pre_rst_go", int'(Go), 1);
    Reset = 1'b1;
    @(posedge Clock);
    sample();
    check("mid_rst_go", int'(Go), 0);
    check("mid_rst_go_count", int'(Go_count), 0);
    check("mid_rst_running", int'(Running), 1);
    Reset = 1'b0;
    Turbo = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
